key_event_decoder: RTL and testbench



---
 rtl/key_event_pkg.sv | 17 +
 rtl/key_event_decoder.sv | 152 +++++++++++++++
 tb/tb_key_event_decoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: FSM state encoding and default tick constants.
package key_event_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t PRESSED   = 3'd1;
  localparam state_t LONG_HELD = 3'd2;
  localparam state_t WAIT_GAP  = 3'd3;
  localparam state_t SECOND    = 3'd4;

  // 50 MHz system clock: 1 s long press, 300 ms double-press gap
  localparam int DEF_LONG_TICKS = 50_000_000;
  localparam int DEF_GAP_TICKS  = 15_000_000;
  localparam int DEF_CNT_W      = 26;

endpackage

// File: rtl/key_event_decoder.sv
// Turns the debounced key level into short/long/double press pulses and a record_en level.
// Optional double-press detection is compiled in with `define KEY_DOUBLE_PRESS_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic record_en,
  output logic busy
);

  if (LONG_TICKS < 2 || GAP_TICKS < 2 ||
      (longint'(1) << CNT_W) <= longint'(LONG_TICKS) ||
      (longint'(1) << CNT_W) <= longint'(GAP_TICKS)) begin : g_param_check
    $error("key_event_decoder: LONG_TICKS/GAP_TICKS must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef KEY_DOUBLE_PRESS_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_d;
  logic             short_nxt, long_nxt, record_nxt;
`ifdef KEY_DOUBLE_PRESS_EN
  logic             double_nxt;
`endif

  // key_d resets high so a key held through reset must be released before it counts
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      key_d       <= 1'b1;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      record_en   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_d       <= key_in;
      short_press <= short_nxt;
      long_press  <= long_nxt;
      record_en   <= record_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

`ifdef KEY_DOUBLE_PRESS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) double_press <= 1'b0;
    else        double_press <= double_nxt;
  end
`else
  assign double_press = 1'b0;
`endif

  // Release beats the long threshold, repress beats the gap timeout
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (key_in && !key_d) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        if (!key_in) begin
`ifdef KEY_DOUBLE_PRESS_EN
          state_nxt = WAIT_GAP;
`else
          state_nxt = IDLE;
`endif
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!key_in) state_nxt = IDLE;
      end
`ifdef KEY_DOUBLE_PRESS_EN
      WAIT_GAP: begin
        if (key_in) begin
          state_nxt = SECOND;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      SECOND: begin
        if (!key_in) state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    record_nxt = record_en;
`ifdef KEY_DOUBLE_PRESS_EN
    double_nxt = 1'b0;
`endif
    case (state)
      PRESSED: begin
        if (!key_in) begin
`ifndef KEY_DOUBLE_PRESS_EN
          short_nxt = 1'b1;
`endif
        end else if (cnt == LONG_LAST) begin
          long_nxt   = 1'b1;
          record_nxt = 1'b0;
        end
      end
`ifdef KEY_DOUBLE_PRESS_EN
      WAIT_GAP: begin
        if (!key_in && cnt == GAP_LAST) short_nxt = 1'b1;
      end
      SECOND: begin
        if (!key_in) double_nxt = 1'b1;
      end
`endif
      default: ;
    endcase
    if (short_nxt) record_nxt = !record_en;
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: scenario table, random key traffic against a timing-rule model, reset cases.
module tb_key_event_decoder;

  localparam int LONG_T = 100;
  localparam int GAP_T  = 30;
  localparam int CW     = 8;
`ifdef KEY_DOUBLE_PRESS_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  logic key_in;
  logic short_press, long_press, double_press, record_en, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  key_event_decoder #(
    .LONG_TICKS(LONG_T),
    .GAP_TICKS (GAP_T),
    .CNT_W     (CW)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .key_in      (key_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .record_en   (record_en),
    .busy        (busy)
  );

  bit stim[$];
  bit exp_s[], exp_l[], exp_d[], exp_r[], exp_b[];
  int chg[];
  bit rec_model;
  int cnt_s, cnt_l, cnt_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int find_low(input int from);
    for (int i = from; i < stim.size(); i++)
      if (!stim[i]) return i;
    return stim.size();
  endfunction

  // Expected outputs after each sampled edge, derived from press/release positions in stim
  task automatic build_expected(input bit init_prev);
    int n, s, p, r, q, fin;
    bit prev, rec;
    n = stim.size();
    exp_s = new[n]; exp_l = new[n]; exp_d = new[n]; exp_r = new[n]; exp_b = new[n];
    chg = new[n];
    s = 0;
    forever begin
      p = -1;
      for (int i = s; i < n; i++) begin
        prev = (i == 0) ? init_prev : stim[i-1];
        if (stim[i] && !prev) begin p = i; break; end
      end
      if (p < 0) break;
      r = find_low(p + 1);
      if (r > p + LONG_T) begin
        fin = r;
        if (p + LONG_T < n) begin exp_l[p+LONG_T] = 1'b1; chg[p+LONG_T] = 2; end
      end else if (!DBL) begin
        fin = r;
        if (r < n) begin exp_s[r] = 1'b1; chg[r] = 1; end
      end else begin
        q = -1;
        for (int j = 1; j <= GAP_T; j++)
          if (r + j < n && stim[r+j]) begin q = r + j; break; end
        if (q >= 0) begin
          fin = find_low(q + 1);
          if (fin < n) exp_d[fin] = 1'b1;
        end else begin
          fin = r + GAP_T;
          if (fin < n) begin exp_s[fin] = 1'b1; chg[fin] = 1; end
        end
      end
      for (int i = p; i < fin && i < n; i++) exp_b[i] = 1'b1;
      if (fin >= n) break;
      s = fin + 1;
    end
    rec = rec_model;
    for (int i = 0; i < n; i++) begin
      if (chg[i] == 1) rec = !rec;
      else if (chg[i] == 2) rec = 1'b0;
      exp_r[i] = rec;
    end
    rec_model = rec;
  endtask

  task automatic run_seq(input string name, input bit init_prev);
    build_expected(init_prev);
    cnt_s = 0; cnt_l = 0; cnt_d = 0;
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk_in);
      key_in = stim[i];
      @(posedge clk_in);
      #1;
      cnt_s += int'(short_press);
      cnt_l += int'(long_press);
      cnt_d += int'(double_press);
      check($sformatf("%s cyc%0d {short,long,double,rec,busy}", name, i),
            {short_press, long_press, double_press, record_en, busy},
            {exp_s[i], exp_l[i], exp_d[i], exp_r[i], exp_b[i]});
    end
  endtask

  task automatic push_level(input bit v, input int len);
    for (int i = 0; i < len; i++) stim.push_back(v);
  endtask

  typedef struct {
    int hi1;
    int lo;
    int hi2;
    int n_short;
    int n_long;
    int n_dbl;
  } row_t;

  row_t rows[8];
  bit   rec_tbl;

  initial begin
    rows[0] = '{20,  0,  0,   1,            0,          0};
    rows[1] = '{150, 0,  0,   0,            1,          0};
    rows[2] = '{100, 0,  0,   1,            0,          0};
    rows[3] = '{101, 0,  0,   0,            1,          0};
    rows[4] = '{10,  10, 10,  DBL ? 0 : 2,  0,          DBL ? 1 : 0};
    rows[5] = '{10,  30, 10,  DBL ? 0 : 2,  0,          DBL ? 1 : 0};
    rows[6] = '{10,  31, 10,  2,            0,          0};
    rows[7] = '{10,  5,  150, DBL ? 0 : 1,  DBL ? 0 : 1, DBL ? 1 : 0};

    rst_in = 1'b1;
    key_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset outputs {short,long,double,rec,busy}",
          {short_press, long_press, double_press, record_en, busy}, 5'b0);
    @(negedge clk_in);
    rst_in = 1'b0;
    rec_model = 1'b0;
    rec_tbl   = 1'b0;

    for (int k = 0; k < 8; k++) begin
      stim.delete();
      push_level(1'b0, 3);
      push_level(1'b1, rows[k].hi1);
      if (rows[k].hi2 > 0) begin
        push_level(1'b0, rows[k].lo);
        push_level(1'b1, rows[k].hi2);
      end
      push_level(1'b0, GAP_T + 5);
      run_seq($sformatf("row%0d", k), 1'b0);
      check($sformatf("row%0d short count", k), cnt_s, rows[k].n_short);
      check($sformatf("row%0d long count", k),  cnt_l, rows[k].n_long);
      check($sformatf("row%0d double count", k), cnt_d, rows[k].n_dbl);
      if (rows[k].n_long > 0) rec_tbl = 1'b0;
      else if (rows[k].n_short % 2 == 1) rec_tbl = !rec_tbl;
      check($sformatf("row%0d record_en", k), record_en, rec_tbl);
    end

    for (int b = 0; b < 6; b++) begin
      stim.delete();
      push_level(1'b0, 2);
      for (int seg = 0; seg < 4; seg++) begin
        case ($urandom_range(0, 3))
          0:       push_level(1'b1, $urandom_range(1, 3));
          1:       push_level(1'b1, $urandom_range(LONG_T - 1, LONG_T + 2));
          default: push_level(1'b1, $urandom_range(1, 140));
        endcase
        case ($urandom_range(0, 2))
          0:       push_level(1'b0, $urandom_range(GAP_T - 1, GAP_T + 2));
          default: push_level(1'b0, $urandom_range(1, 45));
        endcase
      end
      push_level(1'b0, GAP_T + 5);
      run_seq($sformatf("rand%0d", b), 1'b0);
    end

    // Key held through reset release: only the later press may count
    @(negedge clk_in);
    rst_in = 1'b1;
    key_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    rec_model = 1'b0;
    stim.delete();
    push_level(1'b1, 15);
    push_level(1'b0, 5);
    push_level(1'b1, 20);
    push_level(1'b0, GAP_T + 5);
    run_seq("held_reset", 1'b1);
    check("held_reset short count", cnt_s, 1);
    check("held_reset long count", cnt_l, 0);
    check("held_reset record_en", record_en, 1);

    // Reset asserted while PRESSED
    @(negedge clk_in);
    key_in = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    check("mid_reset busy before reset", busy, 1);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("mid_reset outputs async {short,long,double,rec,busy}",
          {short_press, long_press, double_press, record_en, busy}, 5'b0);
    @(posedge clk_in);
    #1;
    check("mid_reset outputs next cycle {short,long,double,rec,busy}",
          {short_press, long_press, double_press, record_en, busy}, 5'b0);
    @(negedge clk_in);
    key_in = 1'b0;
    rst_in = 1'b0;
    rec_model = 1'b0;
    stim.delete();
    push_level(1'b0, GAP_T + LONG_T + 5);
    run_seq("after_mid_reset", 1'b1);
    check("after_mid_reset pulse count", cnt_s + cnt_l + cnt_d, 0);

    stim.delete();
    push_level(1'b0, 2);
    push_level(1'b1, 20);
    push_level(1'b0, GAP_T + 5);
    run_seq("press20", 1'b0);
    check("press20 short count", cnt_s, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
